// File: rtl/sram512x8_pkg.sv
// sram512x8_pkg
//   Shared constants and types for the SRAM1RW512x8 front-end controller.
//   SRAM_ADDR_W / SRAM_DATA_W / SRAM_WORDS describe the macro geometry.
//   ctrl_state_t is the controller FSM state (zero-fill, then traffic).
package sram512x8_pkg;

    localparam int SRAM_ADDR_W = 9;
    localparam int SRAM_DATA_W = 8;
    localparam int SRAM_WORDS  = 512;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } ctrl_state_t;

endpackage

// File: rtl/sram_rsp_fifo.sv
// sram_rsp_fifo
//   Synchronous first-word-fall-through FIFO holding read responses.
//   Ports:
//     clk, rst          clock, synchronous active-high reset (pointers/count)
//     push, push_data   write one entry (caller guarantees space)
//     pop               remove head; ignored when empty
//     out_valid         FIFO non-empty
//     out_data          head entry, zero when empty
//     count             current occupancy 0..DEPTH
module sram_rsp_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 8,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_pop;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop    = pop && (count != '0);
    assign out_valid = (count != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)   wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/sram512x8_ctrl.sv
// sram512x8_ctrl
//   Front-end controller for one SRAM1RW512x8 macro (single port, 1-cycle
//   synchronous read, OEB-gated output). After reset the array is zero-filled,
//   then valid/ready requests are turned into registered SRAM pin commands.
//   Read data returns in order through a credit-managed response FIFO.
//   Ports:
//     clk, rst                       clock (also SRAM CE), sync active-high reset
//     req_valid/req_ready            request handshake
//     req_we, req_addr, req_wdata    1 = write / 0 = read, address, write data
//     rsp_valid/rsp_ready, rsp_data  in-order read responses (FWFT head)
//     init_done                      high once RUN is entered
//     sram_a/csb/web/oeb/i           registered SRAM controls
//     sram_o                         SRAM read data
module sram512x8_ctrl
    import sram512x8_pkg::*;
#(
    parameter int                NUM_WORDS  = SRAM_WORDS,
    parameter int                ADDR_W     = SRAM_ADDR_W,
    parameter int                DATA_W     = SRAM_DATA_W,
    parameter int                RSP_DEPTH  = 4,
    parameter int                INIT_EN    = 1,
    parameter logic [DATA_W-1:0] INIT_VALUE = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              init_done,
    output logic [ADDR_W-1:0] sram_a,
    output logic              sram_csb,
    output logic              sram_web,
    output logic              sram_oeb,
    output logic [DATA_W-1:0] sram_i,
    input  logic [DATA_W-1:0] sram_o
);

    localparam int INIT_CNT_W = $clog2(NUM_WORDS + 1);
    localparam int FIFO_CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int OCC_W      = FIFO_CNT_W + 1;

    ctrl_state_t           state;
    logic [INIT_CNT_W-1:0] init_cnt;
    logic [FIFO_CNT_W-1:0] fifo_count;
    logic                  req_acc;
    logic                  rd_acc;
    logic                  rsp_pop;
    logic                  rd_vld_p0;
    logic                  rd_vld_p1;
    logic [OCC_W-1:0]      occ_next;

    assign req_acc = req_valid && req_ready;
    assign rd_acc  = req_acc && !req_we;
    assign rsp_pop = rsp_valid && rsp_ready;

    // Credits in use after this edge: in-flight reads plus buffered words.
    // A capture only moves a credit from the pipe into the FIFO, so the
    // net change is just new reads minus pops.
    assign occ_next = OCC_W'(fifo_count) + OCC_W'(rd_vld_p0) + OCC_W'(rd_vld_p1)
                    + OCC_W'(rd_acc) - OCC_W'(rsp_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            if (INIT_EN != 0) state <= INIT;
            else              state <= RUN;
            init_cnt  <= '0;
            sram_csb  <= 1'b1;
            sram_web  <= 1'b1;
            sram_oeb  <= 1'b1;
            sram_a    <= '0;
            sram_i    <= '0;
            req_ready <= 1'b0;
            init_done <= 1'b0;
            rd_vld_p0 <= 1'b0;
            rd_vld_p1 <= 1'b0;
        end else begin
            // p0: read command registered; p1: SRAM executing the read.
            rd_vld_p0 <= rd_acc;
            rd_vld_p1 <= rd_vld_p0;
            case (state)
                INIT: begin
                    if (init_cnt == INIT_CNT_W'(NUM_WORDS)) begin
                        state     <= RUN;
                        sram_csb  <= 1'b1;
                        sram_web  <= 1'b1;
                        sram_oeb  <= 1'b0;
                        init_done <= 1'b1;
                        req_ready <= (occ_next < OCC_W'(RSP_DEPTH));
                    end else begin
                        sram_csb <= 1'b0;
                        sram_web <= 1'b0;
                        sram_a   <= init_cnt[ADDR_W-1:0];
                        sram_i   <= INIT_VALUE;
                        init_cnt <= init_cnt + 1'b1;
                    end
                end
                RUN: begin
                    sram_oeb  <= 1'b0;
                    init_done <= 1'b1;
                    req_ready <= (occ_next < OCC_W'(RSP_DEPTH));
                    if (req_acc) begin
                        sram_csb <= 1'b0;
                        sram_web <= ~req_we;
                        sram_a   <= req_addr;
                        sram_i   <= req_wdata;
                    end else begin
                        sram_csb <= 1'b1;
                        sram_web <= 1'b1;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

    // p2: sram_o captured into the response FIFO.
    sram_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (DATA_W)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rd_vld_p1),
        .push_data (sram_o),
        .pop       (rsp_pop),
        .out_valid (rsp_valid),
        .out_data  (rsp_data),
        .count     (fifo_count)
    );

    // Credits should make a capture into a full FIFO impossible.
    always @(posedge clk) begin
        if (!rst && rd_vld_p1) begin
            assert (fifo_count < FIFO_CNT_W'(RSP_DEPTH));
        end
    end

endmodule

// File: tb/tb_sram512x8_ctrl.sv
// tb_sram512x8_ctrl
//   Directed bench for sram512x8_ctrl with a behavioural SRAM1RW512x8 model.
module tb_sram512x8_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic [8:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       init_done;
    logic [8:0] sram_a;
    logic       sram_csb;
    logic       sram_web;
    logic       sram_oeb;
    logic [7:0] sram_i;
    logic [7:0] sram_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sram512x8_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .init_done (init_done),
        .sram_a    (sram_a),
        .sram_csb  (sram_csb),
        .sram_web  (sram_web),
        .sram_oeb  (sram_oeb),
        .sram_i    (sram_i),
        .sram_o    (sram_o)
    );

    // SRAM model: commands execute at the clock edge; output gated by OEB.
    logic [7:0] mem [512];
    logic [7:0] sram_dout;
    logic       fill;

    always @(posedge clk) begin
        if (fill) begin
            for (int j = 0; j < 512; j++) mem[j] <= 8'hA5;
        end else if (!sram_csb) begin
            if (!sram_web) mem[sram_a] <= sram_i;
            else           sram_dout   <= mem[sram_a];
        end
    end

    assign sram_o = sram_oeb ? 8'hzz : sram_dout;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    int bad;
    int nrsp;
    int acc;
    int nrsp_at_acc5;

    initial begin
        rst = 1'b1; fill = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b0;
        step();
        fill = 1'b0;
        step();

        // Reset state
        chk("rst_csb",       sram_csb,  1);
        chk("rst_web",       sram_web,  1);
        chk("rst_oeb",       sram_oeb,  1);
        chk("rst_a",         sram_a,    0);
        chk("rst_i",         sram_i,    0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data",  rsp_data,  0);
        chk("rst_init_done", init_done, 0);

        // Zero-fill: 512 consecutive writes of 00, requests blocked
        rst = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 9'h1FF;
        bad = 0;
        for (int k = 0; k < 512; k++) begin
            step();
            if (sram_csb !== 1'b0 || sram_web !== 1'b0 || sram_a !== k[8:0] ||
                sram_i !== 8'h00 || req_ready !== 1'b0 || init_done !== 1'b0) bad++;
        end
        chk("init_seq_bad", bad, 0);
        req_valid = 1'b0;
        step();
        chk("init_done_rise", init_done, 1);
        chk("run_req_ready",  req_ready, 1);
        chk("run_csb_idle",   sram_csb,  1);
        chk("run_oeb",        sram_oeb,  0);

        // Write 1A5=C3 then read it back-to-back
        req_valid = 1'b1; req_we = 1'b1; req_addr = 9'h1A5; req_wdata = 8'hC3;
        step();
        chk("wr_csb", sram_csb, 0);
        chk("wr_web", sram_web, 0);
        chk("wr_a",   sram_a,   9'h1A5);
        chk("wr_i",   sram_i,   8'hC3);
        req_we = 1'b0; req_wdata = 8'h00;
        step();
        chk("rd_web", sram_web, 1);
        req_valid = 1'b0;
        step();
        chk("rd_lat1_valid", rsp_valid, 0);
        chk("idle_a_hold",   sram_a,    9'h1A5);
        chk("idle_csb",      sram_csb,  1);
        step();
        chk("rd_lat2_valid", rsp_valid, 1);
        chk("rd_data_c3",    rsp_data,  8'hC3);
        rsp_ready = 1'b1;
        step();
        chk("rd_popped", rsp_valid, 0);

        // Unwritten address reads back the fill value
        req_valid = 1'b1; req_addr = 9'h1FF;
        step();
        req_valid = 1'b0;
        step();
        step();
        chk("unwr_valid", rsp_valid, 1);
        chk("unwr_data",  rsp_data,  8'h00);
        step();

        // Preload 0x10..0x1F with addr ^ 5A, then stream 16 reads
        req_valid = 1'b1; req_we = 1'b1;
        bad = 0;
        for (int k = 0; k < 16; k++) begin
            req_addr  = 9'(16 + k);
            req_wdata = 8'(16 + k) ^ 8'h5A;
            if (req_ready !== 1'b1) bad++;
            step();
        end
        chk("wr_stream_ready", bad, 0);
        req_we = 1'b0;
        bad = 0; nrsp = 0;
        for (int c = 0; c < 19; c++) begin
            if (c < 16) begin
                req_valid = 1'b1; req_addr = 9'(16 + c);
                if (req_ready !== 1'b1) bad++;
            end else begin
                req_valid = 1'b0;
            end
            step();
            if (rsp_valid === 1'b1) begin
                if (rsp_data !== (8'(16 + nrsp) ^ 8'h5A)) bad++;
                nrsp++;
            end
        end
        chk("stream_bad",   bad,       0);
        chk("stream_count", nrsp,      16);
        chk("stream_drain", rsp_valid, 0);

        // Backpressure: 6 reads with consumer stalled, only 4 credits
        rsp_ready = 1'b0; acc = 0;
        for (int c = 0; c < 8; c++) begin
            req_valid = 1'b1; req_addr = 9'(16 + acc);
            if (req_ready === 1'b1) acc++;
            step();
        end
        chk("bp_accepted",  acc,       4);
        chk("bp_ready_low", req_ready, 0);
        chk("bp_sram_idle", sram_csb,  1);
        chk("bp_valid",     rsp_valid, 1);
        chk("bp_head",      rsp_data,  8'h4A);
        rsp_ready = 1'b1; nrsp = 0; bad = 0; nrsp_at_acc5 = -1;
        for (int c = 0; c < 20; c++) begin
            if (acc < 6) begin
                req_valid = 1'b1; req_addr = 9'(16 + acc);
            end else begin
                req_valid = 1'b0;
            end
            if (req_valid && req_ready === 1'b1) begin
                if (acc == 4) nrsp_at_acc5 = nrsp;
                acc++;
            end
            if (rsp_valid === 1'b1) begin
                if (rsp_data !== (8'(16 + nrsp) ^ 8'h5A)) bad++;
                nrsp++;
            end
            step();
        end
        chk("bp_total_acc",   acc,          6);
        chk("bp_total_rsp",   nrsp,         6);
        chk("bp_order_bad",   bad,          0);
        chk("bp_late_accept", nrsp_at_acc5, 1);
        chk("bp_drain",       rsp_valid,    0);

        // Mid-operation reset with 2 in flight and 2 buffered
        rsp_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            req_valid = 1'b1; req_addr = 9'(16 + c);
            step();
        end
        req_valid = 1'b0;
        chk("pre_rst_valid", rsp_valid, 1);
        chk("pre_rst_ready", req_ready, 0);
        rst = 1'b1;
        step();
        chk("mrst_valid",     rsp_valid, 0);
        chk("mrst_data",      rsp_data,  0);
        chk("mrst_csb",       sram_csb,  1);
        chk("mrst_ready",     req_ready, 0);
        chk("mrst_init_done", init_done, 0);
        chk("mrst_oeb",       sram_oeb,  1);
        rst = 1'b0; rsp_ready = 1'b1;
        step();
        chk("reinit_a",   sram_a,   0);
        chk("reinit_csb", sram_csb, 0);
        chk("reinit_web", sram_web, 0);
        bad = (rsp_valid === 1'b1) ? 1 : 0;
        for (int k = 1; k < 513; k++) begin
            step();
            if (rsp_valid === 1'b1) bad++;
        end
        chk("no_stale_rsp",  bad,       0);
        chk("reinit_done",   init_done, 1);
        chk("reinit_ready",  req_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
